mcs4_bus_sched: RTL and testbench
=================================

// Module: mcs4_bus_sched
// PURPOSE
// - Sequences the shared 4-bit MCS-4 data bus between the i4004 core and the memory/IO back end.
// - Tracks the 8-phase instruction cycle (A1..X3) from sync and latches the 12-bit fetch address.
// - Issues ROM fetch and RAM/IO requests over ready/ack handshakes.
// - Stalls the core through cpu_ce until the back end answers; steers returned data onto the core's dbus_in.
// PARAMETERS
// - ADDR_W       12     fetch address width; must be 12
// - TIMEOUT_CYC  64     ack watchdog limit in clk cycles; used only with MCS4_BUS_TIMEOUT_EN
// - IDLE_NIB     4'h0   value driven on dbus_to_cpu when no source owns the bus
// PORTS
// - clk          in   1       system clock
// - rst_n        in   1       synchronous reset, active low
// - sync         in   1       core sync; high during X3
// - cpu_dbus     in   4       core dbus_out
// - cm_ram       in   4       core RAM bank select
// - cpu_ce       out  1       core clock enable; core phase advances only when high
// - dbus_to_cpu  out  4       core dbus_in
// - rom_req      out  1       ROM fetch request; level, held until ack
// - rom_addr     out  ADDR_W  fetch address; stable while rom_req is high
// - rom_ack      in   1       ROM data valid
// - rom_data     in   8       {OPR, OPA}
// - io_req       out  1       RAM/IO request; level, held until ack
// - io_cmd       out  4       OPA of the 0xE group instruction; bit3=1 means read
// - io_src       out  8       chip/register address latched by the last SRC
// - io_bank      out  4       cm_ram value captured with that SRC
// - io_wdata     out  4       write nibble (cpu_dbus during a stalled X2)
// - io_ack       in   1       IO done; io_rdata valid when io_cmd[3]=1
// - io_rdata     in   4       read nibble
// - sync_err     out  1       sticky: sync seen outside X3
// - timeout_err  out  1       sticky: watchdog expired; constant 0 without the macro
// BEHAVIOUR
// - Reset values: ph=A1, all outputs 0 except cpu_ce=1; dw_pend=0; rom_buf_vld=0.
//   rst_n low mid-handshake drops rom_req/io_req in the same cycle. An ack arriving during reset is ignored.
// - Phase: ph advances A1..X3 only on cycles with cpu_ce=1. After X3 it wraps to A1.
//   - sync=1 with cpu_ce=1 at ph!=X3: set sync_err; ph <= A1.
//   - sync is ignored while cpu_ce=0.
// - Address: with cpu_ce=1, latch cpu_dbus at A1/A2/A3 into rom_addr[3:0]/[7:4]/[11:8].
// - Fetch: on the A3 edge, rom_req <= 1 and rom_buf_vld <= 0.
//   - rom_ack is accepted on a cycle where rom_req=1 (same-cycle ack allowed).
//   - Accepting rom_ack: store rom_data, set rom_buf_vld, and rom_req <= 0.
//   - An ack while req=0 is ignored.
// - Stall: cpu_ce = !((ph==M1 && !rom_buf_vld) || (ph==X2 && io_pend)). cpu_ce is combinational from registers.
//   - Minimum fetch stall is 1 cycle (zero-wait ack).
// - Bus steering: dbus_to_cpu = buf[7:4] at M1, buf[3:0] at M2, io_rd_buf at X2 for a read op; IDLE_NIB otherwise.
// - Decode at M2 (cpu_ce=1), skipped when dw_pend=1:
//   - Double-word ops set dw_pend for the next instruction cycle: OPR in {1,4,5,7}, or OPR=2 with OPA[0]=0.
//     dw_pend clears at the end of X3 of the second word.
//   - SRC (OPR=2, OPA[0]=1): latch cpu_dbus at X2 -> io_src[7:4] and at X3 -> io_src[3:0].
//     Latch cm_ram -> io_bank at X2. No io_req for SRC.
//   - OPR=0xE: io_cmd <= OPA. io_req <= 1 and io_pend <= 1 on the X1->X2 edge.
//     io_wdata mirrors cpu_dbus; it is stable because the core is frozen.
//   - io_ack accepted: io_req <= 0 and io_pend <= 0. On a read, io_rd_buf <= io_rdata. cpu_ce rises the next cycle.
// - io_src and io_bank persist until the next SRC. A 0xE op before any SRC uses the reset values 0.
// CONFIGURATION
// - MCS4_BUS_TIMEOUT_EN defined:
//   - A counter runs while rom_req or io_req is high.
//   - At TIMEOUT_CYC cycles: drop the request, set timeout_err, and treat the buffer as 8'hFF (rom) / 4'hF (io).
//   - The core resumes with that value.
// - MCS4_BUS_TIMEOUT_EN undefined: stall is unbounded; timeout_err tied 0; no counter logic.
// TESTING
// - Reset, then A1..A3 drive 3,2,1 -> rom_req=1, rom_addr=12'h123; ack 1 cycle later with 8'hD5.
//   -> dbus_to_cpu=D at M1, 5 at M2; cpu_ce low exactly 2 cycles.
// - Fetch 8'h21 (SRC), X2=4, X3=7, cm_ram=4'b0010; then fetch 8'hE9.
//   -> io_req at X2, io_cmd=9, io_src=8'h47, io_bank=2.
//   -> io_rdata=A returned on dbus_to_cpu at X2.
// - Fetch 8'h40 (JUN) then 8'hE0 as word two -> no io_req, dw_pend cleared after X3. The next 8'hE0 issues io_req.
// - sync pulsed at ph=M2 -> sync_err=1, next phase A1. sync while cpu_ce=0 -> no effect.
// - rst_n low while io_req=1 for 3 cycles -> io_req=0, cpu_ce=1, ph=A1; a late io_ack is ignored.
// - MCS4_BUS_TIMEOUT_EN, TIMEOUT_CYC=8, no rom_ack -> rom_req drops after 8 cycles.
//   -> timeout_err=1; dbus_to_cpu=F at M1 and at M2.

Source files
------------

// File: rtl/mcs4_bus_sched_if.sv
// Bus bundle between the i4004 core, the MCS-4 bus scheduler and the ROM/RAM/IO back end.
interface mcs4_bus_sched_if #(
  parameter int ADDR_W = 12
) ();
  logic              sync;
  logic [3:0]        cpu_dbus;
  logic [3:0]        cm_ram;
  logic              cpu_ce;
  logic [3:0]        dbus_to_cpu;
  logic              rom_req;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_ack;
  logic [7:0]        rom_data;
  logic              io_req;
  logic [3:0]        io_cmd;
  logic [7:0]        io_src;
  logic [3:0]        io_bank;
  logic [3:0]        io_wdata;
  logic              io_ack;
  logic [3:0]        io_rdata;
  logic              sync_err;
  logic              timeout_err;

  modport master (
    input  sync, cpu_dbus, cm_ram, rom_ack, rom_data, io_ack, io_rdata,
    output cpu_ce, dbus_to_cpu, rom_req, rom_addr, io_req, io_cmd, io_src,
           io_bank, io_wdata, sync_err, timeout_err
  );

  modport slave (
    output sync, cpu_dbus, cm_ram, rom_ack, rom_data, io_ack, io_rdata,
    input  cpu_ce, dbus_to_cpu, rom_req, rom_addr, io_req, io_cmd, io_src,
           io_bank, io_wdata, sync_err, timeout_err
  );
endinterface

// File: rtl/mcs4_bus_sched.sv
// MCS-4 bus scheduler: tracks the A1..X3 cycle, runs ROM/IO handshakes and stalls the core via cpu_ce.
// Define MCS4_BUS_TIMEOUT_EN to add the ack watchdog (timeout_err, forced 8'hFF / 4'hF data).
module mcs4_bus_sched #(
  parameter int         ADDR_W      = 12,
  parameter int         TIMEOUT_CYC = 64,
  parameter logic [3:0] IDLE_NIB    = 4'h0
) (
  input logic              clk,
  input logic              rst_n,
  mcs4_bus_sched_if.master bus
);

  localparam logic [2:0] PH_A1 = 3'd0;
  localparam logic [2:0] PH_A2 = 3'd1;
  localparam logic [2:0] PH_A3 = 3'd2;
  localparam logic [2:0] PH_M1 = 3'd3;
  localparam logic [2:0] PH_M2 = 3'd4;
  localparam logic [2:0] PH_X1 = 3'd5;
  localparam logic [2:0] PH_X2 = 3'd6;
  localparam logic [2:0] PH_X3 = 3'd7;

  generate
    if (ADDR_W != 12 || TIMEOUT_CYC < 2) begin : g_bad_param
      $error("mcs4_bus_sched: ADDR_W must be 12 and TIMEOUT_CYC at least 2");
    end
  endgenerate

  logic [2:0]        ph_q, ph_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rom_req_q, rom_req_d;
  logic [7:0]        rom_buf_q, rom_buf_d;
  logic              rom_buf_vld_q, rom_buf_vld_d;
  logic              dw_pend_q, dw_pend_d;
  logic              dw_next_q, dw_next_d;
  logic              is_src_q, is_src_d;
  logic              is_io_q, is_io_d;
  logic [3:0]        io_cmd_q, io_cmd_d;
  logic              io_req_q, io_req_d;
  logic              io_pend_q, io_pend_d;
  logic [3:0]        io_rd_buf_q, io_rd_buf_d;
  logic [7:0]        io_src_q, io_src_d;
  logic [3:0]        io_bank_q, io_bank_d;
  logic              sync_err_q, sync_err_d;
  logic              cpu_ce_s;
  logic              dw_op_s;
  logic              rom_acc_s;
  logic              io_acc_s;
  logic [3:0]        opr_s, opa_s;
  logic [3:0]        dbus_s;
`ifdef MCS4_BUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              timeout_err_q, timeout_err_d;
`endif

  assign opr_s     = rom_buf_q[7:4];
  assign opa_s     = rom_buf_q[3:0];
  assign dw_op_s   = (opr_s == 4'h1) || (opr_s == 4'h4) || (opr_s == 4'h5) ||
                     (opr_s == 4'h7) || ((opr_s == 4'h2) && !opa_s[0]);
  assign cpu_ce_s  = !(((ph_q == PH_M1) && !rom_buf_vld_q) || ((ph_q == PH_X2) && io_pend_q));
  assign rom_acc_s = rom_req_q && bus.rom_ack;
  assign io_acc_s  = io_req_q && bus.io_ack;

  // Data steering onto the core's dbus_in.
  always_comb begin
    case (ph_q)
      PH_M1:   dbus_s = rom_buf_q[7:4];
      PH_M2:   dbus_s = rom_buf_q[3:0];
      PH_X2:   dbus_s = (is_io_q && io_cmd_q[3]) ? io_rd_buf_q : IDLE_NIB;
      default: dbus_s = IDLE_NIB;
    endcase
  end

  // Next-state logic: phase tracking, decode and both handshakes.
  always_comb begin
    ph_d          = ph_q;
    addr_d        = addr_q;
    rom_req_d     = rom_req_q;
    rom_buf_d     = rom_buf_q;
    rom_buf_vld_d = rom_buf_vld_q;
    dw_pend_d     = dw_pend_q;
    dw_next_d     = dw_next_q;
    is_src_d      = is_src_q;
    is_io_d       = is_io_q;
    io_cmd_d      = io_cmd_q;
    io_req_d      = io_req_q;
    io_pend_d     = io_pend_q;
    io_rd_buf_d   = io_rd_buf_q;
    io_src_d      = io_src_q;
    io_bank_d     = io_bank_q;
    sync_err_d    = sync_err_q;
`ifdef MCS4_BUS_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q;
`endif
    if (cpu_ce_s) begin
      if (bus.sync && (ph_q != PH_X3)) begin
        sync_err_d = 1'b1;
        ph_d       = PH_A1;
      end else begin
        ph_d = ph_q + 3'd1;
      end
      case (ph_q)
        PH_A1: addr_d[3:0] = bus.cpu_dbus;
        PH_A2: addr_d[7:4] = bus.cpu_dbus;
        PH_A3: begin
          addr_d[11:8]  = bus.cpu_dbus;
          rom_req_d     = 1'b1;
          rom_buf_vld_d = 1'b0;
        end
        // The second word of a double-word op is operand data, never decoded.
        PH_M2: begin
          if (!dw_pend_q) begin
            is_src_d  = (opr_s == 4'h2) && opa_s[0];
            is_io_d   = (opr_s == 4'hE);
            dw_next_d = dw_op_s;
            io_cmd_d  = (opr_s == 4'hE) ? opa_s : io_cmd_q;
          end else begin
            is_src_d  = 1'b0;
            is_io_d   = 1'b0;
            dw_next_d = 1'b0;
          end
        end
        PH_X1: begin
          io_req_d  = io_req_q || is_io_q;
          io_pend_d = io_pend_q || is_io_q;
        end
        PH_X2: begin
          io_src_d[7:4] = is_src_q ? bus.cpu_dbus : io_src_q[7:4];
          io_bank_d     = is_src_q ? bus.cm_ram : io_bank_q;
        end
        PH_X3: begin
          io_src_d[3:0] = is_src_q ? bus.cpu_dbus : io_src_q[3:0];
          is_src_d      = 1'b0;
          is_io_d       = 1'b0;
          dw_pend_d     = dw_next_q;
          dw_next_d     = 1'b0;
        end
        default: ph_d = ph_d;
      endcase
    end else begin
      ph_d = ph_q;
    end
    if (rom_acc_s) begin
      rom_buf_d     = bus.rom_data;
      rom_buf_vld_d = 1'b1;
      rom_req_d     = 1'b0;
    end else begin
      rom_buf_d = rom_buf_d;
    end
    if (io_acc_s) begin
      io_req_d    = 1'b0;
      io_pend_d   = 1'b0;
      io_rd_buf_d = io_cmd_q[3] ? bus.io_rdata : io_rd_buf_q;
    end else begin
      io_rd_buf_d = io_rd_buf_q;
    end
`ifdef MCS4_BUS_TIMEOUT_EN
    // An ack on the expiry cycle wins over the watchdog.
    if ((rom_req_q || io_req_q) && !rom_acc_s && !io_acc_s) begin
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        tmo_cnt_d     = {TMO_W{1'b0}};
        timeout_err_d = 1'b1;
        rom_req_d     = 1'b0;
        io_req_d      = 1'b0;
        io_pend_d     = 1'b0;
        rom_buf_d     = rom_req_q ? 8'hFF : rom_buf_d;
        rom_buf_vld_d = rom_buf_vld_d || rom_req_q;
        io_rd_buf_d   = io_req_q ? 4'hF : io_rd_buf_d;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
      end
    end else begin
      tmo_cnt_d = {TMO_W{1'b0}};
    end
`endif
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph_q          <= PH_A1;
      addr_q        <= {ADDR_W{1'b0}};
      rom_req_q     <= 1'b0;
      rom_buf_q     <= 8'h00;
      rom_buf_vld_q <= 1'b0;
      dw_pend_q     <= 1'b0;
      dw_next_q     <= 1'b0;
      is_src_q      <= 1'b0;
      is_io_q       <= 1'b0;
      io_cmd_q      <= 4'h0;
      io_req_q      <= 1'b0;
      io_pend_q     <= 1'b0;
      io_rd_buf_q   <= 4'h0;
      io_src_q      <= 8'h00;
      io_bank_q     <= 4'h0;
      sync_err_q    <= 1'b0;
`ifdef MCS4_BUS_TIMEOUT_EN
      tmo_cnt_q     <= {TMO_W{1'b0}};
      timeout_err_q <= 1'b0;
`endif
    end else begin
      ph_q          <= ph_d;
      addr_q        <= addr_d;
      rom_req_q     <= rom_req_d;
      rom_buf_q     <= rom_buf_d;
      rom_buf_vld_q <= rom_buf_vld_d;
      dw_pend_q     <= dw_pend_d;
      dw_next_q     <= dw_next_d;
      is_src_q      <= is_src_d;
      is_io_q       <= is_io_d;
      io_cmd_q      <= io_cmd_d;
      io_req_q      <= io_req_d;
      io_pend_q     <= io_pend_d;
      io_rd_buf_q   <= io_rd_buf_d;
      io_src_q      <= io_src_d;
      io_bank_q     <= io_bank_d;
      sync_err_q    <= sync_err_d;
`ifdef MCS4_BUS_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign bus.cpu_ce      = cpu_ce_s;
  assign bus.dbus_to_cpu = dbus_s;
  assign bus.rom_req     = rom_req_q;
  assign bus.rom_addr    = addr_q;
  assign bus.io_req      = io_req_q;
  assign bus.io_cmd      = io_cmd_q;
  assign bus.io_src      = io_src_q;
  assign bus.io_bank     = io_bank_q;
  assign bus.io_wdata    = bus.cpu_dbus;
  assign bus.sync_err    = sync_err_q;
`ifdef MCS4_BUS_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mcs4_bus_sched.sv
// Bench for mcs4_bus_sched: plays the i4004 core and back end, predicts behaviour from an instruction-level model.
module tb_mcs4_bus_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;

  // Instruction-level model state (the core's view of the bus).
  logic [7:0] src_m = 8'h00;
  logic [3:0] bank_m = 4'h0;
  bit         dw_m = 1'b0;
  bit         serr_m = 1'b0;

  always #5 clk = ~clk;

  mcs4_bus_sched_if #(.ADDR_W(12)) bus ();

  mcs4_bus_sched #(.ADDR_W(12), .TIMEOUT_CYC(8), .IDLE_NIB(4'h0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Phases A1..M1: drive the address, answer the fetch after dly wait cycles.
  task automatic fetch(input logic [11:0] a, input logic [7:0] d, input int dly, input bit sync_stall);
    int stall;
    check_eq("ce_a1", bus.cpu_ce, 1);
    check_eq("dbus_a1", bus.dbus_to_cpu, 4'h0);
    bus.cpu_dbus = a[3:0];
    step();
    bus.io_ack = 1'b0;
    bus.cpu_dbus = a[7:4];
    step();
    bus.cpu_dbus = a[11:8];
    step();
    check_eq("rom_req", bus.rom_req, 1);
    check_eq("rom_addr", bus.rom_addr, a);
    check_eq("io_req_m1", bus.io_req, 0);
    bus.sync = sync_stall;
    stall = 0;
    while (!bus.cpu_ce && stall < 40) begin
      bus.rom_ack  = (stall == dly);
      bus.rom_data = (stall == dly) ? d : ~d;
      step();
      stall++;
    end
    bus.rom_ack = 1'b0;
    bus.sync = 1'b0;
    check_eq("fetch_stall", stall, dly + 1);
    check_eq("rom_req_drop", bus.rom_req, 0);
    check_eq("dbus_m1", bus.dbus_to_cpu, d[7:4]);
    check_eq("sync_err", bus.sync_err, serr_m);
    step();
  endtask

  // Phases M2..X3 and the model update for one instruction word.
  task automatic exec(input logic [7:0] d, input logic [3:0] x2n, input logic [3:0] x3n,
                      input logic [3:0] bank, input logic [3:0] rdata, input int io_dly);
    bit is_io, is_src, is_dw;
    int stall;
    is_io  = (d[7:4] == 4'hE) && !dw_m;
    is_src = (d[7:4] == 4'h2) && d[0] && !dw_m;
    is_dw  = !dw_m && ((d[7:4] inside {4'h1, 4'h4, 4'h5, 4'h7}) || ((d[7:4] == 4'h2) && !d[0]));
    check_eq("dbus_m2", bus.dbus_to_cpu, d[3:0]);
    step();
    check_eq("dbus_x1", bus.dbus_to_cpu, 4'h0);
    check_eq("io_req_x1", bus.io_req, 0);
    step();
    bus.cpu_dbus = x2n;
    bus.cm_ram = bank;
    if (is_io) begin
      check_eq("io_req_x2", bus.io_req, 1);
      check_eq("io_cmd", bus.io_cmd, d[3:0]);
      check_eq("io_src_use", bus.io_src, src_m);
      check_eq("io_bank_use", bus.io_bank, bank_m);
      stall = 0;
      while (!bus.cpu_ce && stall < 40) begin
        bus.io_ack   = (stall == io_dly);
        bus.io_rdata = (stall == io_dly) ? rdata : ~rdata;
        step();
        stall++;
      end
      bus.io_ack = 1'b0;
      check_eq("io_stall", stall, io_dly + 1);
      check_eq("io_wdata", bus.io_wdata, x2n);
      check_eq("io_req_drop", bus.io_req, 0);
      check_eq("dbus_x2", bus.dbus_to_cpu, d[3] ? rdata : 4'h0);
    end else begin
      check_eq("io_req_none", bus.io_req, 0);
      check_eq("ce_x2", bus.cpu_ce, 1);
      check_eq("dbus_x2_idle", bus.dbus_to_cpu, 4'h0);
    end
    step();
    bus.cpu_dbus = x3n;
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    if (is_src) begin
      src_m  = {x2n, x3n};
      bank_m = bank;
    end
    dw_m = is_dw;
    check_eq("io_src", bus.io_src, src_m);
    check_eq("io_bank", bus.io_bank, bank_m);
    check_eq("sync_err_x3", bus.sync_err, serr_m);
  endtask

  task automatic instr(input logic [11:0] a, input logic [7:0] d, input logic [3:0] x2n,
                       input logic [3:0] x3n, input logic [3:0] bank, input logic [3:0] rdata);
    fetch(a, d, $urandom_range(0, 3), 1'b0);
    exec(d, x2n, x3n, bank, rdata, $urandom_range(0, 3));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int cnt;
    bus.sync = 1'b0;     bus.cpu_dbus = 4'h0; bus.cm_ram = 4'h0;
    bus.rom_ack = 1'b1;  bus.rom_data = 8'hAA; bus.io_ack = 1'b0; bus.io_rdata = 4'h0;
    repeat (3) step();
    check_eq("rst_ce", bus.cpu_ce, 1);
    check_eq("rst_rom_req", bus.rom_req, 0);
    check_eq("rst_io_req", bus.io_req, 0);
    check_eq("rst_dbus", bus.dbus_to_cpu, 4'h0);
    check_eq("rst_addr", bus.rom_addr, 12'h000);
    check_eq("rst_io_src", bus.io_src, 8'h00);
    check_eq("rst_sync_err", bus.sync_err, 0);
    check_eq("rst_timeout_err", bus.timeout_err, 0);
    bus.rom_ack = 1'b0;
    rst_n = 1'b1;

    fetch(12'h123, 8'hD5, 1, 1'b0);
    exec(8'hD5, 4'h0, 4'h0, 4'h0, 4'h0, 0);
    fetch(12'h124, 8'h21, 0, 1'b0);
    exec(8'h21, 4'h4, 4'h7, 4'b0010, 4'h0, 0);
    fetch(12'h125, 8'hE9, 0, 1'b0);
    exec(8'hE9, 4'h3, 4'h0, 4'h0, 4'hA, 1);
    instr(12'h126, 8'h40, 4'h0, 4'h0, 4'h0, 4'h0);
    instr(12'h127, 8'hE0, 4'h0, 4'h0, 4'h0, 4'h0);
    instr(12'h128, 8'hE0, 4'h5, 4'h0, 4'h0, 4'h0);
    fetch(12'h129, 8'hD5, 2, 1'b1);
    exec(8'hD5, 4'h0, 4'h0, 4'h0, 4'h0, 0);

    // sync at M2 forces A1 and latches sync_err.
    fetch(12'h12A, 8'hD5, 0, 1'b0);
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
    serr_m = 1'b1;
    check_eq("sync_err_m2", bus.sync_err, 1);
    instr(12'h200, 8'hD1, 4'h0, 4'h0, 4'h0, 4'h0);

    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      case ($urandom_range(0, 5))
        0, 1:    d[7:4] = 4'hE;
        2:       d[7:4] = 4'h2;
        default: d[7:4] = d[7:4];
      endcase
      instr(12'($urandom), d, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    end

    // Reset while io_req is pending; a late io_ack must be ignored.
    instr(12'h300, 8'hD0, 4'h0, 4'h0, 4'h0, 4'h0);
    fetch(12'h301, 8'hE1, 0, 1'b0);
    step();
    step();
    check_eq("io_req_pre_rst", bus.io_req, 1);
    rst_n = 1'b0;
    repeat (3) step();
    check_eq("rst_mid_io_req", bus.io_req, 0);
    check_eq("rst_mid_ce", bus.cpu_ce, 1);
    check_eq("rst_mid_serr", bus.sync_err, 0);
    rst_n = 1'b1;
    bus.io_ack = 1'b1;
    src_m = 8'h00; bank_m = 4'h0; dw_m = 1'b0; serr_m = 1'b0;
    instr(12'h400, 8'hE8, 4'h0, 4'h0, 4'h0, 4'h6);

`ifdef MCS4_BUS_TIMEOUT_EN
    bus.cpu_dbus = 4'h1; step();
    bus.cpu_dbus = 4'h2; step();
    bus.cpu_dbus = 4'h3; step();
    cnt = 0;
    while (bus.rom_req && cnt < 40) begin
      step();
      cnt++;
    end
    check_eq("tmo_len", cnt, 8);
    check_eq("tmo_err", bus.timeout_err, 1);
    check_eq("tmo_ce", bus.cpu_ce, 1);
    check_eq("tmo_dbus_m1", bus.dbus_to_cpu, 4'hF);
    step();
    exec(8'hFF, 4'h0, 4'h0, 4'h0, 4'h0, 0);
`else
    cnt = 0;
    check_eq("timeout_tied", bus.timeout_err, cnt);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
